cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 113 +++++++++++
 tb/tb_cacheline_adapter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cacheline fill/write-back requests into four 64-bit memory beats.
// A single FSM serialises bursts; writes take priority when both requests arrive together.
module cacheline_adapter #(
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [63:0]  mem_wdata,
    input  logic         mem_ready,
    input  logic [63:0]  mem_rdata,
    input  logic         mem_rvalid
);

    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic [255:0] rdata_q, rdata_d;

    // Offset bits within the line never reach memory.
    logic unused_offset;
    assign unused_offset = ^dfp_addr[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 256'd0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dfp_write)     state_d = WRITE;
                else if (dfp_read) state_d = RD_REQ;
            end
            RD_REQ:  if (mem_ready) state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid && beat_q == LAST_BEAT) state_d = RESP;
            WRITE:   if (mem_ready && beat_q == LAST_BEAT) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat counter wraps naturally from 3 to 0 as the final beat completes.
    always_comb begin
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    addr_d  = {dfp_addr[31:5], 5'b0};
                    wdata_d = dfp_wdata;
                    beat_d  = 2'd0;
                end else if (dfp_read) begin
                    addr_d = {dfp_addr[31:5], 5'b0};
                    beat_d = 2'd0;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d[64*beat_q +: 64] = mem_rdata;
                    beat_d                   = beat_q + 2'd1;
                end
            end
            WRITE: begin
                if (mem_ready) beat_d = beat_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_read  = (state_q == RD_REQ);
        mem_write = (state_q == WRITE);
        dfp_resp  = (state_q == RESP);
        mem_addr  = addr_q;
        mem_wdata = wdata_q[64*beat_q +: 64];
        dfp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: bench-side memory responder plus hand-computed lines.
// Cycle numbering: the negedge after request-sampling edge N+j is counted as k = j+1 (cycle N+j+1).
module tb_cacheline_adapter;

    logic         clk;
    logic         rst_n;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;

    cacheline_adapter #(.BURST_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] L2 = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                   64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
    localparam logic [255:0] L3 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                   64'h5555AAAA5555AAAA, 64'hC0FFEE00C0FFEE00};
    localparam logic [255:0] W1 = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2,
                                   64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
    localparam logic [255:0] W2 = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
                                   64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};

    int resp_k[$];
    int first_rd_k;
    int first_wr_k;
    int rd_acc;
    int wbeat_n;

    // Present a request on the next negedge; stray rvalid may already be active.
    task automatic request(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [255:0] wd, input bit stray);
        @(negedge clk);
        dfp_read   = rd;
        dfp_write  = wr;
        dfp_addr   = a;
        dfp_wdata  = wd;
        mem_ready  = 1'b1;
        mem_rvalid = stray;
        mem_rdata  = 64'hDEAD;
    endtask

    // Memory responder: stalls each write beat, returns read beats back-to-back after accept.
    task automatic run_bus(input int n_resp, input int stall, input bit stray,
                           input logic [31:0] exp_addr, input logic [255:0] wline,
                           input logic [255:0] rline);
        int k          = 0;
        int stall_left = stall;
        int rbeat      = 0;
        bit rd_pend    = 1'b0;
        bit saw_wr     = 1'b0;
        resp_k.delete();
        first_rd_k = -1;
        first_wr_k = -1;
        rd_acc     = 0;
        wbeat_n    = 0;
        @(posedge clk);
        while (resp_k.size() < n_resp && k < 200) begin
            @(negedge clk);
            k++;
            if (dfp_resp) begin
                resp_k.push_back(k);
                if (saw_wr) dfp_write = 1'b0;
                else        dfp_read  = 1'b0;
                saw_wr = 1'b0;
            end
            if (mem_read || mem_write) chk_eq("mem_addr", mem_addr, exp_addr);
            if (mem_read && first_rd_k < 0)  first_rd_k = k;
            if (mem_write && first_wr_k < 0) first_wr_k = k;
            mem_ready = 1'b1;
            if (mem_write) begin
                saw_wr = 1'b1;
                chk_eq("mem_wdata", mem_wdata, wline[64*wbeat_n +: 64]);
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    wbeat_n++;
                    stall_left = stall;
                end
            end
            mem_rvalid = stray;
            mem_rdata  = 64'hDEAD;
            if (rd_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rline[64*rbeat +: 64];
                rbeat++;
                if (rbeat == 4) rd_pend = 1'b0;
            end
            if (mem_read) begin
                rd_acc++;
                rd_pend = 1'b1;
                rbeat   = 0;
            end
        end
        chk_eq("resp_count", resp_k.size(), n_resp);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk_eq("resp_one_cycle", dfp_resp, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_mem_read"},  mem_read,  1'b0);
        chk_eq({tag, "_mem_write"}, mem_write, 1'b0);
        chk_eq({tag, "_dfp_resp"},  dfp_resp,  1'b0);
        chk_eq({tag, "_mem_addr"},  mem_addr,  32'h0);
        chk_eq({tag, "_mem_wdata"}, mem_wdata, 64'h0);
        chk_eq({tag, "_dfp_rdata"}, dfp_rdata, 256'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        dfp_addr   = 32'h0;
        dfp_read   = 1'b0;
        dfp_write  = 1'b0;
        dfp_wdata  = 256'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 64'h0;
        mem_rvalid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Fill from 0x1234: aligned base 0x1220, response in cycle N+6.
        request(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b0);
        run_bus(1, 0, 1'b0, 32'h0000_1220, 256'h0, L1);
        chk_eq("rd_latency", resp_k[0], 6);
        chk_eq("rd_accepts", rd_acc, 1);
        chk_eq("rd_data", dfp_rdata, L1);

        // Stray rvalid while idle leaves the fill untouched.
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        repeat (3) @(negedge clk);
        mem_rvalid = 1'b0;
        chk_eq("idle_stray_rdata", dfp_rdata, L1);

        // Write-back with two stall cycles ahead of every beat, stray rvalid throughout.
        request(1'b0, 1'b1, 32'h8000_0040, W1, 1'b1);
        run_bus(1, 2, 1'b1, 32'h8000_0040, W1, 256'h0);
        chk_eq("wr_stall_latency", resp_k[0], 13);
        chk_eq("wr_beats", wbeat_n, 4);
        chk_eq("wr_keeps_rdata", dfp_rdata, L1);

        // Both requests held: write first, one IDLE cycle, then the read.
        request(1'b1, 1'b1, 32'h0000_011F, W2, 1'b0);
        run_bus(2, 0, 1'b0, 32'h0000_0100, W2, L2);
        chk_eq("both_first_is_write", first_wr_k, 1);
        chk_eq("both_wr_latency", resp_k[0], 5);
        chk_eq("both_one_idle", first_rd_k, resp_k[0] + 2);
        chk_eq("both_rd_resp", resp_k[1], resp_k[0] + 7);
        chk_eq("both_wr_beats", wbeat_n, 4);
        chk_eq("both_rd_data", dfp_rdata, L2);

        // Reset lands in RD_WAIT after two beats have been captured.
        request(1'b1, 1'b0, 32'h0000_0200, 256'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("mid_rd_req", mem_read, 1'b1);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1;
        @(negedge clk);
        mem_rdata  = 64'h2;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk_eq("mid_partial_fill", dfp_rdata[127:0], {64'h2, 64'h1});
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        dfp_read = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_no_resp", dfp_resp, 1'b0);
        rst_n = 1'b1;

        request(1'b1, 1'b0, 32'h0000_0208, 256'h0, 1'b0);
        run_bus(1, 0, 1'b0, 32'h0000_0200, 256'h0, L3);
        chk_eq("post_rst_latency", resp_k[0], 6);
        chk_eq("post_rst_data", dfp_rdata, L3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
